gray_deco_display: RTL
======================

# gray_deco_display

Gray-to-binary decoder with a two-digit seven-segment display. It is the receive-side counterpart of the board's binary-to-Gray encoder top level and targets the same FPGA board.

- A 4-bit Gray code from switches is synchronized and sampled at a fixed refresh rate.
- The sample is decoded to binary, driven onto active-low LEDs and converted to BCD tens/units.
- The two digits are time-multiplexed onto a common-anode display.

## Interface

- WIDTH, 4, code width; only 4 supported (display range 0–15). Any other value is an elaboration error.
- REFRESH, 13500000, input sampling period in clk_i cycles; must be ≥ 2.
- DISPLAY_REFRESH, 27000000, digit scan period in clk_i cycles; must be ≥ 2.

Ports:

- clk_i  input  1  single system clock; all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- codigo_gray_i  input  WIDTH  Gray code from switches, asynchronous to clk_i.
- codigo_bin_led  output  WIDTH  decoded binary, active-low (LED lit = bit 1).
- anodo  output  2  digit enables, active-low; bit0 = units, bit1 = tens.
- catodo  output  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation

- **Synchronizer:** two flops (sync1, sync2) on codigo_gray_i, updated every cycle.
- **Sampling counter cuenta:**
  - Width $clog2(REFRESH); reset value REFRESH-1; decrements by 1 each cycle.
  - At 0 it reloads REFRESH-1.
  - en_lectura = (cuenta == 0), a one-cycle pulse with period exactly REFRESH.
- **Sample register gray_r:** loads sync2 on the edge where en_lectura = 1; holds otherwise.
- **Decode stage (registered, 1 cycle after gray_r):**
  - bin_r[3] = gray_r[3]; bin_r[i] = bin_r[i+1] XOR gray_r[i] for i = 2..0.
  - unidades_r = bin % 10 and decenas_r = bin / 10 (0 or 1), computed from the same combinational decode and registered together with bin_r.
- **LED output:** codigo_bin_led = ~bin_r.
- **Scan counter cuenta_display:** same structure as cuenta with DISPLAY_REFRESH; en_conmutador = (cuenta_display == 0).
- **Scan FSM, 2 states, reset state S_UNITS:**
  - S_UNITS → S_TENS on en_conmutador.
  - S_TENS → S_UNITS on en_conmutador.
  - Otherwise hold.
- **Display decode:** combinational from FSM state and registered digits only; no combinational path from any input.
  - S_UNITS: anodo = 2'b10, catodo = seg(unidades_r).
  - S_TENS, decenas_r = 1: anodo = 2'b01, catodo = seg(1) = 7'b1111001.
  - S_TENS, decenas_r = 0 (leading-zero blank): anodo = 2'b11, catodo = 7'b1111111.
- **seg() table:**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other value = 1111111.

## Timing

- **Reset:**
  - With rst_i = 0 at an edge, all registers clear: sync, gray_r, bin_r, digits = 0; FSM = S_UNITS; counters = N-1.
  - Outputs one edge after reset: codigo_bin_led = 4'b1111, anodo = 2'b10, catodo = 7'b1000000.
  - Reset mid-operation behaves identically and aborts any in-flight sample.
- **First pulses after release:**
  - The first en_lectura falls REFRESH-1 cycles after the first non-reset edge.
  - en_conmutador is analogous with DISPLAY_REFRESH.
- **Sample path latency:** switch change → sync2 in 2 edges → gray_r at the next en_lectura edge → bin_r/LED/digits 1 edge later.
  - Worst-case pin-to-LED latency: 3 + REFRESH cycles.
- **Ignored input changes:** values present at sync2 only between pulses are never sampled; a glitch shorter than REFRESH can be missed entirely.
- **Simultaneous pulses:** en_lectura and en_conmutador in the same cycle are independent. The FSM toggles using the previous digits; the new digits appear one edge later.
- **Wrap-around:** counters never underflow; the reload at 0 takes priority over decrement.

## Test plan

Bench parameters: REFRESH = 4, DISPLAY_REFRESH = 3.

1. **Reset:** rst_i = 0 for 5 cycles with codigo_gray_i = 4'b1010 → codigo_bin_led = 4'b1111, anodo = 2'b10, catodo = 7'b1000000 throughout; gray_r stays 0.
2. **Exhaustive decode:** sweep all 16 Gray codes, each held 8 cycles → bin matches the XOR-chain decode. Examples:
   - 4'b1000 → led 4'b0000, units 5 (0010010), tens 1 (1111001, anodo 01).
   - 4'b0110 → led 4'b1011, units 4, tens phase anodo 11 / catodo 1111111.
3. **Sampling window:** apply 4'b0011 for 1 cycle between pulses, otherwise 4'b0001 → LED never shows 4'b1101 (binary 2); it stays 4'b1110 (binary 1).
4. **Scan cadence:** with bin = 12 (gray 4'b1010), anodo alternates 10/01 every 3 cycles.
   - catodo = 0100100 in the units phase and 1111001 in the tens phase.
   - No cycle has both anodo bits low.
5. **Reset mid-operation:** with bin = 13 in S_TENS, pulse rst_i low for 1 cycle → next edge gives reset outputs.
   - The first new en_lectura occurs exactly 4 cycles after release.

Source files
------------

// File: rtl/gray_deco_display_if.sv
// Bundle for the Gray-decoder display block.
//   codigo_gray_i  : Gray code from the switches (asynchronous to clk_i)
//   codigo_bin_led : decoded binary, active-low LEDs
//   anodo          : digit enables, active-low (bit0 = units, bit1 = tens)
//   catodo         : segments {g,f,e,d,c,b,a}, active-low
// master drives the switches and observes the display; slave is the decoder.
interface gray_deco_display_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] codigo_gray_i;
  logic [WIDTH-1:0] codigo_bin_led;
  logic [1:0]       anodo;
  logic [6:0]       catodo;

  modport master (
    output codigo_gray_i,
    input  codigo_bin_led,
    input  anodo,
    input  catodo
  );

  modport slave (
    input  codigo_gray_i,
    output codigo_bin_led,
    output anodo,
    output catodo
  );
endinterface

// File: rtl/gray_deco_display.sv
// Gray-to-binary decoder with a two-digit multiplexed seven-segment display.
// The switch code is synchronised, sampled once every REFRESH cycles,
// decoded to binary (shown on active-low LEDs) and split into tens/units
// that are scanned onto a common-anode display every DISPLAY_REFRESH cycles.
// Ports:
//   clk_i : system clock, all logic on the rising edge
//   rst_i : synchronous active-low reset
//   bus   : gray_deco_display_if.slave (switch input, LED/anode/cathode outputs)
module gray_deco_display #(
  parameter int WIDTH           = 4,
  parameter int REFRESH         = 13500000,
  parameter int DISPLAY_REFRESH = 27000000
) (
  input logic                 clk_i,
  input logic                 rst_i,
  gray_deco_display_if.slave  bus
);

  generate
    if (WIDTH != 4) begin : g_bad_width
      $error("gray_deco_display: only WIDTH = 4 is supported");
    end
    if (REFRESH < 2) begin : g_bad_refresh
      $error("gray_deco_display: REFRESH must be >= 2");
    end
    if (DISPLAY_REFRESH < 2) begin : g_bad_display_refresh
      $error("gray_deco_display: DISPLAY_REFRESH must be >= 2");
    end
  endgenerate

  localparam int CW  = $clog2(REFRESH);
  localparam int DCW = $clog2(DISPLAY_REFRESH);
  localparam logic [CW-1:0]  RELOAD   = CW'(REFRESH - 1);
  localparam logic [DCW-1:0] D_RELOAD = DCW'(DISPLAY_REFRESH - 1);

  typedef enum logic {
    S_UNITS,
    S_TENS
  } state_t;

  function automatic logic [6:0] seg(input logic [WIDTH-1:0] d);
    logic [6:0] s;
    unique case (d)
      WIDTH'(0): s = 7'b1000000;
      WIDTH'(1): s = 7'b1111001;
      WIDTH'(2): s = 7'b0100100;
      WIDTH'(3): s = 7'b0110000;
      WIDTH'(4): s = 7'b0011001;
      WIDTH'(5): s = 7'b0010010;
      WIDTH'(6): s = 7'b0000010;
      WIDTH'(7): s = 7'b1111000;
      WIDTH'(8): s = 7'b0000000;
      WIDTH'(9): s = 7'b0010000;
      default:   s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [WIDTH-1:0] sync1, sync2, gray_r, bin_r, unidades_r;
  logic             decenas_r;
  logic [CW-1:0]    cuenta;
  logic [DCW-1:0]   cuenta_display;
  logic             en_lectura, en_conmutador;
  state_t           state;

  logic [WIDTH-1:0] bin_c, unidades_c;
  logic             decenas_c;
  logic [1:0]       anodo_c;
  logic [6:0]       catodo_c;

  assign en_lectura    = (cuenta == '0);
  assign en_conmutador = (cuenta_display == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.codigo_gray_i;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)             cuenta <= RELOAD;
    else if (en_lectura)    cuenta <= RELOAD;
    else                    cuenta <= cuenta - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)             cuenta_display <= D_RELOAD;
    else if (en_conmutador) cuenta_display <= D_RELOAD;
    else                    cuenta_display <= cuenta_display - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)          gray_r <= '0;
    else if (en_lectura) gray_r <= sync2;
  end

  // Binary bit i is the XOR of Gray bits i..MSB; written as a reduction over
  // the shifted code so no bit of bin_c depends on another bit of bin_c.
  always_comb begin
    bin_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin_c[i] = ^(gray_r >> i);
    end
    decenas_c  = (bin_c >= WIDTH'(10));
    unidades_c = decenas_c ? (bin_c - WIDTH'(10)) : bin_c;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bin_r      <= '0;
      unidades_r <= '0;
      decenas_r  <= 1'b0;
    end else begin
      bin_r      <= bin_c;
      unidades_r <= unidades_c;
      decenas_r  <= decenas_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= S_UNITS;
    end else if (en_conmutador) begin
      unique case (state)
        S_UNITS: state <= S_TENS;
        S_TENS:  state <= S_UNITS;
        default: state <= S_UNITS;
      endcase
    end
  end

  // Tens digit is only ever 0 or 1; a zero tens digit is blanked.
  always_comb begin
    anodo_c  = 2'b11;
    catodo_c = 7'b1111111;
    unique case (state)
      S_UNITS: begin
        anodo_c  = 2'b10;
        catodo_c = seg(unidades_r);
      end
      S_TENS: begin
        if (decenas_r) begin
          anodo_c  = 2'b01;
          catodo_c = 7'b1111001;
        end
      end
      default: begin
        anodo_c  = 2'b11;
        catodo_c = 7'b1111111;
      end
    endcase
  end

  assign bus.codigo_bin_led = ~bin_r;
  assign bus.anodo          = anodo_c;
  assign bus.catodo         = catodo_c;

endmodule
